// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the hardwired-zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: the EX-stage load writes a register the
// ID-stage instruction reads. Writes to x0 never create a dependency.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       memread,
  input  logic [4:0] rd_addr,
  output logic       luse
);

  assign luse = memread & (rd_addr != REG_ZERO) &
                ((rd_addr == rs1_addr) | (rd_addr == rs2_addr));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubble, MEM-resolved branch flush,
// memory-wait freeze with timeout watchdog. HAZARD_CTRL_PERF_EN adds perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_addr_i,
  input  logic             exmem_branch_i,
  input  logic             exmem_zero_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_flush_o,
  output logic             pipe_hold_o,
  output logic             mem_err_o,
`ifdef HAZARD_CTRL_PERF_EN
  input  logic             perf_clr_i,
  output logic [CNT_W-1:0] perf_stall_o,
  output logic [CNT_W-1:0] perf_flush_o,
  output logic [CNT_W-1:0] perf_wait_o,
`endif
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             luse, taken, mem_stall;
  logic             stall_ev, flush_ev;

  hazard_detect u_detect (
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .memread  (idex_memread_i),
    .rd_addr  (idex_rd_addr_i),
    .luse     (luse)
  );

  assign taken     = exmem_branch_i & exmem_zero_i;
  assign mem_stall = mem_req_i & ~mem_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs depend on current inputs so hazards are handled with zero latency.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_flush_o = 1'b0;
    pipe_hold_o   = 1'b0;
    stall_ev      = 1'b0;
    flush_ev      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          pipe_hold_o  = 1'b1;
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          state_d      = ST_MEM_WAIT;
          cnt_d        = CNT_ONE;
        end else if (taken) begin
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
          exmem_flush_o = 1'b1;
          state_d       = ST_FLUSH;
          flush_ev      = 1'b1;
        end else if (luse) begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
          stall_ev      = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        pipe_hold_o  = 1'b1;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        if (mem_ready_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          if (cnt_d >= TIMEOUT_C) err_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Wrong-path ID and bubbled MEM: only a memory stall matters here.
        if (mem_stall) begin
          pipe_hold_o  = 1'b1;
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          state_d      = ST_MEM_WAIT;
          cnt_d        = CNT_ONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (rst_i) begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      exmem_flush_o = 1'b0;
      pipe_hold_o   = 1'b0;
    end
  end

  assign mem_err_o = err_q;
  assign state_o   = state_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (stall_ev && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_ev && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + CNT_ONE;
      if (state_q == ST_MEM_WAIT && wait_cnt_q != CNT_MAX) wait_cnt_q <= wait_cnt_q + CNT_ONE;
    end
  end

  assign perf_stall_o = stall_cnt_q;
  assign perf_flush_o = flush_cnt_q;
  assign perf_wait_o  = wait_cnt_q;
`else
  logic unused_ev;
  assign unused_ev = stall_ev ^ flush_ev;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand-written multi-cycle sequences and
// a randomized run checked against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       memread, br, zero, req, rdy;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, mem_err;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rs1_addr_i     (rs1),
    .rs2_addr_i     (rs2),
    .idex_memread_i (memread),
    .idex_rd_addr_i (rd),
    .exmem_branch_i (br),
    .exmem_zero_i   (zero),
    .mem_req_i      (req),
    .mem_ready_i    (rdy),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .exmem_flush_o  (exmem_flush),
    .pipe_hold_o    (pipe_hold),
    .mem_err_o      (mem_err),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, state, mem_err}
  function automatic logic [8:0] got_vec();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, state, mem_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic mr,
                       input logic [4:0] d, input logic b, input logic z,
                       input logic q, input logic r);
    @(negedge clk);
    rs1 = a1; rs2 = a2; memread = mr; rd = d; br = b; zero = z; req = q; rdy = r;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rs1 = 0; rs2 = 0; memread = 0; rd = 0; br = 0; zero = 0; req = 0; rdy = 0;
    #2;
    chk("reset_outputs", 32'(got_vec()), 32'(9'b1_1_0_0_0_0_00_0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int   m_state;   // 0 run, 1 waiting on memory, 2 one-cycle post-flush
  int   m_wait;    // consecutive held cycles of the current access
  logic m_err;

  function automatic logic m_luse();
    return memread && rd != 0 && (rd == rs1 || rd == rs2);
  endfunction

  function automatic logic [8:0] model_out();
    logic stall_mem;
    logic [5:0] c;
    stall_mem = req && !rdy;
    c = 6'b110000;
    if (rst) return {6'b110000, 2'd0, 1'b0};
    if (m_state == 1) c = 6'b000001;
    else if (m_state == 2) begin
      if (stall_mem) c = 6'b000001;
    end else begin
      if (stall_mem) c = 6'b000001;
      else if (br && zero) c = 6'b111110;
      else if (m_luse()) c = 6'b000100;
    end
    return {c, 2'(m_state), m_err};
  endfunction

  task automatic model_advance();
    logic stall_mem;
    stall_mem = req && !rdy;
    if (m_state == 1) begin
      if (rdy) begin
        m_state = 0; m_wait = 0;
      end else begin
        if (m_wait < 65535) m_wait = m_wait + 1;
        if (m_wait >= TO) m_err = 1'b1;
      end
    end else if (stall_mem) begin
      m_state = 1; m_wait = 1;
    end else if (m_state == 0 && br && zero) begin
      m_state = 2;
    end else begin
      m_state = 0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rs1, rs2;
    logic       mr;
    logic [4:0] rd;
    logic       br, z, req, rdy;
    logic [8:0] exp;
  } vec_t;

  vec_t vt[16];

  initial begin
    rst = 1'b1;
    rs1 = 0; rs2 = 0; memread = 0; rd = 0; br = 0; zero = 0; req = 0; rdy = 0;

    vt[0]  = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_0_0_1_0_0_00_0}; // load-use rs1
    vt[1]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_1_0_0_0_0_00_0}; // load gone
    vt[2]  = '{5'd3, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_1_0_0_0_0_00_0}; // x0 exempt
    vt[3]  = '{5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_0_0_1_0_0_00_0}; // load-use rs2
    vt[4]  = '{5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_1_0_0_0_0_00_0}; // no match
    vt[5]  = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0_0_0_1_0_0_00_0}; // not taken
    vt[6]  = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 9'b1_1_1_1_1_0_00_0}; // taken over luse
    vt[7]  = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 9'b1_1_0_0_0_0_10_0}; // flush ignores both
    vt[8]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b1_1_0_0_0_0_00_0}; // req+ready same cycle
    vt[9]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 9'b0_0_0_0_0_1_00_0}; // mem wait over branch
    vt[10] = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 9'b0_0_0_0_0_1_01_0}; // waiting, luse suppressed
    vt[11] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b0_0_0_0_0_1_01_0}; // ready arrives
    vt[12] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'b1_1_1_1_1_0_00_0}; // taken branch
    vt[13] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b0_0_0_0_0_1_10_0}; // flush -> mem wait
    vt[14] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b0_0_0_0_0_1_01_0}; // ready arrives
    vt[15] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_1_0_0_0_0_00_0}; // back in run

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].rs1, vt[i].rs2, vt[i].mr, vt[i].rd, vt[i].br, vt[i].z, vt[i].req, vt[i].rdy);
      chk($sformatf("vec%0d", i), 32'(got_vec()), 32'(vt[i].exp));
    end

    // Memory wait: three not-ready cycles, then ready.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk($sformatf("wait_hold%0d", i), 32'(pipe_hold), 32'd1);
      chk($sformatf("wait_pc%0d", i), 32'(pc_write), 32'd0);
      chk($sformatf("wait_state%0d", i), 32'(state), (i == 0) ? 32'd0 : 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("wait_ready_state", 32'(state), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wait_back_run", 32'(state), 32'd0);
    chk("wait_back_hold", 32'(pipe_hold), 32'd0);
    chk("wait_no_err", 32'(mem_err), 32'd0);

    // Timeout: error appears after the TO-th held cycle and is sticky.
    do_reset();
    for (int i = 1; i <= TO + 1; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk($sformatf("to_err_c%0d", i), 32'(mem_err), (i > TO) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("to_state_wait", 32'(state), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_state_run", 32'(state), 32'd0);
    chk("to_err_sticky", 32'(mem_err), 32'd1);
    do_reset();
    chk("to_err_cleared", 32'(mem_err), 32'd0);

    // Asynchronous reset between clock edges while waiting on memory.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("arst_pre_state", 32'(state), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_hold", 32'(pipe_hold), 32'd0);
    chk("arst_pc", 32'(pc_write), 32'd1);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;

    // Randomized run against the reference model.
    do_reset();
    m_state = 0; m_wait = 0; m_err = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 79) == 0);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      rd      = 5'($urandom_range(0, 3));
      memread = 1'($urandom_range(0, 1));
      br      = 1'($urandom_range(0, 1));
      zero    = 1'($urandom_range(0, 1));
      req     = ($urandom_range(0, 4) < 2);
      rdy     = ($urandom_range(0, 3) == 0);
      #2;
      if (rst) begin
        m_state = 0; m_wait = 0; m_err = 1'b0;
      end
      chk($sformatf("rand%0d", n), 32'(got_vec()), 32'(model_out()));
      if (!rst) model_advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
